// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor and its interface.
package pll_sup_pkg;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned LOSS_W  = 16;

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_e;

  // Largest of three dwell limits; sizes the shared timer.
  function automatic int unsigned max3_u(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Lock/reset handshake between the rPLL wrapper, the supervisor and the reset tree.
// PLL_LOCK_STATS_EN adds the lock_loss_count statistic.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               lock_in;
  logic               pll_reset;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;
  logic [STATE_W-1:0] state_o;
`ifdef PLL_LOCK_STATS_EN
  logic [LOSS_W-1:0]  lock_loss_count;

  modport master (
    input  lock_in,
    output pll_reset, sys_rst, ready, fault, retry_count, state_o, lock_loss_count
  );

  modport slave (
    output lock_in,
    input  pll_reset, sys_rst, ready, fault, retry_count, state_o, lock_loss_count
  );
`else
  modport master (
    input  lock_in,
    output pll_reset, sys_rst, ready, fault, retry_count, state_o
  );

  modport slave (
    output lock_in,
    input  pll_reset, sys_rst, ready, fault, retry_count, state_o
  );
`endif

endinterface

// File: rtl/sync_bit.sv
// Generic multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies rPLL lock, sequences PLL reset/retry and releases the downstream reset.
// PLL_LOCK_STATS_EN enables the lock-loss counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 27,
  parameter int unsigned LOCK_TIMEOUT   = 27000,
  parameter int unsigned STABLE_CYCLES  = 2700,
  parameter int unsigned MAX_RETRIES    = 4
) (
  input logic                   clkin,
  input logic                   reset,
  pll_lock_supervisor_if.master sup
);

  localparam int unsigned TIMER_MAX = max3_u(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam bit                 RETRY_LIMITED = (MAX_RETRIES != 0);

  sup_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               fail;
  logic               limit_hit;
  logic               lock_s;

  logic pll_reset_q, pll_reset_d;
  logic sys_rst_q,   sys_rst_d;
  logic ready_q,     ready_d;
  logic fault_q,     fault_d;

`ifdef PLL_LOCK_STATS_EN
  logic [LOSS_W-1:0] loss_q, loss_d;
`endif

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (sup.lock_in),
    .q   (lock_s)
  );

  // State, timer, counters and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
`ifdef PLL_LOCK_STATS_EN
      loss_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
`ifdef PLL_LOCK_STATS_EN
      loss_q      <= loss_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they align with state_o.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    fail      = 1'b0;
    retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
    limit_hit = RETRY_LIMITED && ((32'(retry_inc) + 32'd1) > MAX_RETRIES);
`ifdef PLL_LOCK_STATS_EN
    loss_d    = loss_q;
`endif

    unique case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        else                     timer_d = timer_q + TIMER_W'(1);
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s)                  state_d = STABILIZE;
        else if (timer_q == WAIT_LAST) fail  = 1'b1;
        else                         timer_d = timer_q + TIMER_W'(1);
      end
      STABILIZE: begin
        if (!lock_s)                     fail    = 1'b1;
        else if (timer_q == STABLE_LAST) state_d = RUN;
        else                             timer_d = timer_q + TIMER_W'(1);
      end
      RUN: begin
        // Loss after a good lock restarts acquisition without charging a retry.
        if (!lock_s) begin
          state_d = PLL_RST;
          retry_d = '0;
`ifdef PLL_LOCK_STATS_EN
          if (loss_q != LOSS_SAT) loss_d = loss_q + LOSS_W'(1);
`endif
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = limit_hit ? FAULT : PLL_RST;
    end

    if (state_d != state_q) timer_d = '0;

    pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
    sys_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  assign sup.pll_reset   = pll_reset_q;
  assign sup.sys_rst     = sys_rst_q;
  assign sup.ready       = ready_q;
  assign sup.fault       = fault_q;
  assign sup.retry_count = retry_q;
  assign sup.state_o     = state_q;
`ifdef PLL_LOCK_STATS_EN
  assign sup.lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, randomized lock stimulus
// against a behavioural model, and an unlimited-retry instance.
module tb_pll_lock_supervisor;

  localparam int P_SYNC   = 2;
  localparam int P_RST    = 4;
  localparam int P_TO     = 20;
  localparam int P_STABLE = 8;
  localparam int P_MAX    = 3;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic lock_in = 1'b0;
  logic rst0    = 1'b1;
  logic lock0   = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor_if sif ();
  pll_lock_supervisor_if sif0 ();

  assign sif.lock_in  = lock_in;
  assign sif0.lock_in = lock0;

  pll_lock_supervisor #(
    .SYNC_STAGES    (P_SYNC),
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_STABLE),
    .MAX_RETRIES    (P_MAX)
  ) dut (
    .clkin (clk),
    .reset (rst),
    .sup   (sif)
  );

  pll_lock_supervisor #(
    .SYNC_STAGES    (P_SYNC),
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_STABLE),
    .MAX_RETRIES    (0)
  ) dut0 (
    .clkin (clk),
    .reset (rst0),
    .sup   (sif0)
  );

  // Behavioural model: phase number, cycles spent in the phase, lock history queue.
  int m_phase  = 0;
  int m_dwell  = 0;
  int m_fails  = 0;
  int m_losses = 0;
  bit m_sync[$];

  task automatic model_step(input bit r, input bit l);
    bit ls;
    bit failed;
    int nphase;
    if (r) begin
      m_phase = 0; m_dwell = 0; m_fails = 0; m_losses = 0;
      m_sync.delete();
      for (int i = 0; i < P_SYNC; i++) m_sync.push_back(1'b0);
    end else begin
      ls = m_sync.pop_front();
      m_sync.push_back(l);
      nphase = m_phase;
      failed = 1'b0;
      case (m_phase)
        0: if (m_dwell + 1 >= P_RST) nphase = 1;
        1: if (ls) nphase = 2; else if (m_dwell + 1 >= P_TO) failed = 1'b1;
        2: if (!ls) failed = 1'b1; else if (m_dwell + 1 >= P_STABLE) nphase = 3;
        3: if (!ls) begin
             nphase = 0;
             m_fails = 0;
             m_losses = (m_losses < 65535) ? m_losses + 1 : 65535;
           end
        default: nphase = m_phase;
      endcase
      if (failed) begin
        m_fails = (m_fails < 15) ? m_fails + 1 : 15;
        nphase = (P_MAX != 0 && m_fails >= P_MAX) ? 4 : 0;
      end
      m_dwell = (nphase != m_phase || failed) ? 0 : m_dwell + 1;
      m_phase = nphase;
    end
  endtask

  always @(posedge clk) model_step(rst, lock_in);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input int pr, input int sr,
                          input int rdy, input int flt, input int rc, input int loss);
    chk({tag, ".state"},     int'(sif.state_o),     st);
    chk({tag, ".pll_reset"}, int'(sif.pll_reset),   pr);
    chk({tag, ".sys_rst"},   int'(sif.sys_rst),     sr);
    chk({tag, ".ready"},     int'(sif.ready),       rdy);
    chk({tag, ".fault"},     int'(sif.fault),       flt);
    chk({tag, ".retry"},     int'(sif.retry_count), rc);
`ifdef PLL_LOCK_STATS_EN
    chk({tag, ".loss"},      int'(sif.lock_loss_count), loss);
`else
    if (loss < 0) $display("note: negative loss expectation in %s", tag);
`endif
  endtask

  typedef struct {
    bit r;
    bit l;
    int n;
    int st;
    int pr;
    int sr;
    int rdy;
    int flt;
    int rc;
    int loss;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit l, input int n, input int st, input int pr,
                     input int sr, input int rdy, input int flt, input int rc, input int loss);
    vec_t v;
    v.r = r; v.l = l; v.n = n; v.st = st; v.pr = pr; v.sr = sr;
    v.rdy = rdy; v.flt = flt; v.rc = rc; v.loss = loss;
    vt.push_back(v);
  endtask

  initial begin
    bit lvl;
    int run_left;
    bit saw_fault;
    int exp_rc;

    //  rst lock n   st pr sr rdy flt rc loss
    add(1, 0, 1,  0, 1, 1, 0, 0, 0, 0);   // reset state
    add(0, 0, 3,  0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 1, 0, 0, 0, 0);   // pll_reset falls after 4 cycles
    add(0, 0, 5,  1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 2,  1, 0, 1, 0, 0, 0, 0);   // lock rise, still in synchronizer
    add(0, 1, 1,  2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 7,  2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1,  3, 0, 0, 1, 0, 0, 0);   // RUN 11 cycles after lock rise
    add(0, 1, 5,  3, 0, 0, 1, 0, 0, 0);
    add(0, 0, 2,  3, 0, 0, 1, 0, 0, 0);   // loss in RUN
    add(0, 0, 1,  0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 3,  0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1,  1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 1,  2, 0, 1, 0, 0, 0, 1);
    add(0, 1, 3,  2, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1,  2, 0, 1, 0, 0, 0, 1);   // one-cycle glitch
    add(0, 1, 1,  2, 0, 1, 0, 0, 0, 1);
    add(0, 1, 1,  0, 1, 1, 0, 0, 1, 1);   // glitch costs a retry
    add(0, 1, 4,  1, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1,  2, 0, 1, 0, 0, 1, 1);
    add(0, 1, 8,  3, 0, 0, 1, 0, 1, 1);   // clean relock reaches RUN
    add(0, 0, 3,  0, 1, 1, 0, 0, 0, 2);   // loss clears retries
    add(0, 1, 4,  1, 0, 1, 0, 0, 0, 2);
    add(0, 1, 1,  2, 0, 1, 0, 0, 0, 2);
    add(0, 1, 3,  2, 0, 1, 0, 0, 0, 2);
    add(1, 1, 1,  0, 1, 1, 0, 0, 0, 0);   // reset mid-STABILIZE
    add(0, 0, 4,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 19, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0, 1, 1, 0, 0, 1, 0);   // first timeout
    add(0, 0, 24, 0, 1, 1, 0, 0, 2, 0);
    add(0, 0, 23, 1, 0, 1, 0, 0, 2, 0);
    add(0, 0, 1,  4, 1, 1, 0, 1, 3, 0);   // third failure -> FAULT
    add(0, 1, 10, 4, 1, 1, 0, 1, 3, 0);   // FAULT ignores lock
    add(1, 1, 1,  0, 1, 1, 0, 0, 0, 0);   // reset out of FAULT
    add(0, 0, 1,  0, 1, 1, 0, 0, 0, 0);

    foreach (vt[i]) begin
      rst     = vt[i].r;
      lock_in = vt[i].l;
      repeat (vt[i].n) @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vt[i].st, vt[i].pr, vt[i].sr, vt[i].rdy,
               vt[i].flt, vt[i].rc, vt[i].loss);
    end

    // Randomized lock waveform with occasional resets, compared to the model each cycle.
    rst = 1'b1; lock_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_left = 0;
    lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        lvl      = ($urandom_range(0, 2) != 0);
        run_left = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
      end
      run_left--;
      lock_in = lvl;
      rst     = ($urandom_range(0, 249) == 0);
      @(posedge clk); #1;
      chk_outs($sformatf("rnd%0d", c), m_phase,
               (m_phase == 0 || m_phase == 4) ? 1 : 0,
               (m_phase != 3) ? 1 : 0,
               (m_phase == 3) ? 1 : 0,
               (m_phase == 4) ? 1 : 0,
               m_fails, m_losses);
    end
    rst = 1'b0;

    // Unlimited retries: never faults, retry count saturates at 15.
    rst0 = 1'b1; lock0 = 1'b0;
    @(posedge clk); #1;
    chk("inf.reset_state", int'(sif0.state_o), 0);
    chk("inf.reset_retry", int'(sif0.retry_count), 0);
    rst0 = 1'b0;
    saw_fault = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      for (int c = 0; c < P_RST + P_TO; c++) begin
        @(posedge clk); #1;
        if (sif0.fault) saw_fault = 1'b1;
      end
      exp_rc = (k < 15) ? k : 15;
      chk($sformatf("inf.retry%0d", k), int'(sif0.retry_count), exp_rc);
      chk($sformatf("inf.state%0d", k), int'(sif0.state_o), 0);
    end
    chk("inf.no_fault", int'(saw_fault), 0);
    chk("inf.pll_reset", int'(sif0.pll_reset), 1);
    chk("inf.ready", int'(sif0.ready), 0);
    chk("inf.sys_rst", int'(sif0.sys_rst), 1);
`ifdef PLL_LOCK_STATS_EN
    chk("inf.loss", int'(sif0.lock_loss_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
